// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch controller.
//   state_e     : controller mode (RUN, PAUSED, ADJUST)
//   *_DIV_DEF   : default divider lengths for a 100 MHz clock
//   bcd60_t     : one two-digit BCD field (mm or ss), 00..59
//   bcd60_inc() : shared mod-60 BCD incrementer with carry-out
package stopwatch_pkg;

  localparam int unsigned RUN_DIV_DEF   = 100_000_000;
  localparam int unsigned ADJ_DIV_DEF   = 50_000_000;
  localparam int unsigned BLINK_DIV_DEF = 25_000_000;
  localparam int unsigned SCAN_DIV_DEF  = 200_000;

  localparam int unsigned DIGIT_W = 4;

  localparam logic [DIGIT_W-1:0] ONE_MAX = 4'd9;
  localparam logic [DIGIT_W-1:0] TEN_MAX = 4'd5;

  // Blank request for the field being edited: bit0 = sec_one .. bit3 = min_ten
  localparam logic [3:0] BLANK_MIN  = 4'b1100;
  localparam logic [3:0] BLANK_SEC  = 4'b0011;
  localparam logic [3:0] BLANK_NONE = 4'b0000;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_PAUSED = 2'd1,
    ST_ADJUST = 2'd2
  } state_e;

  typedef struct packed {
    logic [DIGIT_W-1:0] ten;
    logic [DIGIT_W-1:0] one;
  } bcd60_t;

  typedef struct packed {
    logic   carry;
    bcd60_t val;
  } bcd60_inc_t;

  // Increment a two-digit BCD field mod 60; carry set on 59 -> 00.
  // The >= compares keep an out-of-range value from escaping the range.
  function automatic bcd60_inc_t bcd60_inc(input bcd60_t v);
    bcd60_inc_t r;
    r.carry = 1'b0;
    r.val   = v;
    if (v.one >= ONE_MAX) begin
      r.val.one = '0;
      if (v.ten >= TEN_MAX) begin
        r.val.ten = '0;
        r.carry   = 1'b1;
      end else begin
        r.val.ten = v.ten + 4'd1;
      end
    end else begin
      r.val.one = v.one + 4'd1;
    end
    return r;
  endfunction

endpackage

// File: rtl/tick_divider.sv
// Free-running modulo-DIV counter producing a one-cycle tick.
//   clk, rst_n : clock, async active-low reset
//   clear      : force count to 0 next cycle
//   hold       : keep count at 0 while asserted
//   tick       : high in the cycle the count equals DIV-1
module tick_divider #(
  parameter int unsigned DIV = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic hold,
  output logic tick
);

  localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] count_q, count_d;

  assign tick = (count_q == LAST);

  // Count up, wrap after the tick, park at zero when held or cleared
  always_comb begin
    count_d = count_q + CNT_W'(1);
    if (clear || hold || tick) begin
      count_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/stopwatch_ctrl.sv
// MM:SS stopwatch controller with run/pause, field adjust and display scan.
//   clk, rst_n          : clock, async active-low reset
//   pause_pulse         : toggle run/pause (one cycle)
//   clr_pulse           : clear time to 00:00 (one cycle)
//   adj, sel            : adjust mode level, field select (0 = min, 1 = sec)
//   sec_one..min_ten    : registered BCD time digits
//   blank_mask          : per-digit blank request for adjust blinking
//   scan_sel            : display digit index
//   paused              : run/pause target is pause
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int unsigned RUN_DIV   = RUN_DIV_DEF,
  parameter int unsigned ADJ_DIV   = ADJ_DIV_DEF,
  parameter int unsigned BLINK_DIV = BLINK_DIV_DEF,
  parameter int unsigned SCAN_DIV  = SCAN_DIV_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               pause_pulse,
  input  logic               clr_pulse,
  input  logic               adj,
  input  logic               sel,
  output logic [DIGIT_W-1:0] sec_one,
  output logic [DIGIT_W-1:0] sec_ten,
  output logic [DIGIT_W-1:0] min_one,
  output logic [DIGIT_W-1:0] min_ten,
  output logic [3:0]         blank_mask,
  output logic [1:0]         scan_sel,
  output logic               paused
);

  state_e     state_q, state_d;
  logic       paused_q, paused_d;
  bcd60_t     sec_q, sec_d;
  bcd60_t     min_q, min_d;
  logic       blink_q, blink_d;
  logic [1:0] scan_q, scan_d;
  logic [3:0] blank_q, blank_d;

  logic       run_tick, adj_tick, blink_tick, scan_tick;
  bcd60_inc_t sec_inc, min_inc;

  // Run second only counts while running, so resume/clear start a full second
  tick_divider #(.DIV(RUN_DIV)) u_run_div (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (clr_pulse),
    .hold  (state_q != ST_RUN),
    .tick  (run_tick)
  );

  // Adjust rate restarts on every entry to adjust mode
  tick_divider #(.DIV(ADJ_DIV)) u_adj_div (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (1'b0),
    .hold  (state_q != ST_ADJUST),
    .tick  (adj_tick)
  );

  tick_divider #(.DIV(BLINK_DIV)) u_blink_div (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (1'b0),
    .hold  (1'b0),
    .tick  (blink_tick)
  );

  tick_divider #(.DIV(SCAN_DIV)) u_scan_div (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (1'b0),
    .hold  (1'b0),
    .tick  (scan_tick)
  );

  assign sec_inc = bcd60_inc(sec_q);
  assign min_inc = bcd60_inc(min_q);

  // Mode FSM, time update, blink/scan and blank mask
  always_comb begin
    state_d  = state_q;
    paused_d = paused_q;
    sec_d    = sec_q;
    min_d    = min_q;
    blink_d  = blink_q;
    scan_d   = scan_q;
    blank_d  = BLANK_NONE;

    // adj takes priority over pause_pulse when entering adjust
    unique case (state_q)
      ST_RUN: begin
        if (adj) begin
          state_d = ST_ADJUST;
        end else if (pause_pulse) begin
          state_d  = ST_PAUSED;
          paused_d = 1'b1;
        end
      end
      ST_PAUSED: begin
        if (adj) begin
          state_d = ST_ADJUST;
        end else if (pause_pulse) begin
          state_d  = ST_RUN;
          paused_d = 1'b0;
        end
      end
      ST_ADJUST: begin
        // paused_q doubles as the return target while adjusting
        if (pause_pulse) begin
          paused_d = !paused_q;
        end
        if (!adj) begin
          state_d = paused_d ? ST_PAUSED : ST_RUN;
        end
      end
      default: begin
        state_d  = ST_RUN;
        paused_d = 1'b0;
      end
    endcase

    // Clear beats any tick in the same cycle
    if (clr_pulse) begin
      sec_d = '0;
      min_d = '0;
    end else if ((state_q == ST_RUN) && run_tick) begin
      sec_d = sec_inc.val;
      if (sec_inc.carry) begin
        min_d = min_inc.val;
      end
    end else if ((state_q == ST_ADJUST) && adj_tick) begin
      // Adjust edits one field only; no carry across fields
      if (sel) begin
        sec_d = sec_inc.val;
      end else begin
        min_d = min_inc.val;
      end
    end

    if (blink_tick) begin
      blink_d = !blink_q;
    end
    if (scan_tick) begin
      scan_d = scan_q + 2'd1;
    end

    // Mask follows the registered state/phase it will be shown with
    if ((state_d == ST_ADJUST) && blink_d) begin
      blank_d = sel ? BLANK_SEC : BLANK_MIN;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_RUN;
      paused_q <= 1'b0;
      sec_q    <= '0;
      min_q    <= '0;
      blink_q  <= 1'b0;
      scan_q   <= '0;
      blank_q  <= BLANK_NONE;
    end else begin
      state_q  <= state_d;
      paused_q <= paused_d;
      sec_q    <= sec_d;
      min_q    <= min_d;
      blink_q  <= blink_d;
      scan_q   <= scan_d;
      blank_q  <= blank_d;
    end
  end

  assign sec_one    = sec_q.one;
  assign sec_ten    = sec_q.ten;
  assign min_one    = min_q.one;
  assign min_ten    = min_q.ten;
  assign blank_mask = blank_q;
  assign scan_sel   = scan_q;
  assign paused     = paused_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed plus randomized bench for stopwatch_ctrl against a seconds-based
// behavioural model (time kept as an integer 0..3599).
module tb_stopwatch_ctrl;

  localparam int RUN_DIV   = 10;
  localparam int ADJ_DIV   = 5;
  localparam int BLINK_DIV = 4;
  localparam int SCAN_DIV  = 2;

  localparam int M_RUN    = 0;
  localparam int M_PAUSED = 1;
  localparam int M_ADJ    = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       pause_pulse = 1'b0;
  logic       clr_pulse = 1'b0;
  logic       adj = 1'b0;
  logic       sel = 1'b0;
  logic [3:0] sec_one, sec_ten, min_one, min_ten;
  logic [3:0] blank_mask;
  logic [1:0] scan_sel;
  logic       paused;

  int checks = 0;
  int errors = 0;

  // Reference model state
  int   m_t, m_mode, m_run_cnt, m_adj_cnt, m_blink_cnt, m_scan_cnt, m_scan;
  bit   m_flag, m_blink;
  logic [3:0] m_mask;

  stopwatch_ctrl #(
    .RUN_DIV   (RUN_DIV),
    .ADJ_DIV   (ADJ_DIV),
    .BLINK_DIV (BLINK_DIV),
    .SCAN_DIV  (SCAN_DIV)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .pause_pulse (pause_pulse),
    .clr_pulse   (clr_pulse),
    .adj         (adj),
    .sel         (sel),
    .sec_one     (sec_one),
    .sec_ten     (sec_ten),
    .min_one     (min_one),
    .min_ten     (min_ten),
    .blank_mask  (blank_mask),
    .scan_sel    (scan_sel),
    .paused      (paused)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic model_reset();
    m_t = 0; m_mode = M_RUN; m_flag = 1'b0;
    m_run_cnt = 0; m_adj_cnt = 0; m_blink_cnt = 0; m_scan_cnt = 0;
    m_blink = 1'b0; m_scan = 0; m_mask = 4'b0000;
  endtask

  // One clock edge of the specified behaviour, inputs as sampled at that edge
  task automatic model_step(input bit p, input bit c, input bit a, input bit s);
    bit rt, at, bt, st;
    int mm, ss;
    rt = (m_run_cnt == RUN_DIV - 1);
    at = (m_adj_cnt == ADJ_DIV - 1);
    bt = (m_blink_cnt == BLINK_DIV - 1);
    st = (m_scan_cnt == SCAN_DIV - 1);
    mm = m_t / 60;
    ss = m_t % 60;
    if (c) m_t = 0;
    else if (m_mode == M_RUN && rt) m_t = (m_t + 1) % 3600;
    else if (m_mode == M_ADJ && at)
      m_t = s ? (mm * 60 + (ss + 1) % 60) : (((mm + 1) % 60) * 60 + ss);
    m_run_cnt   = (c || m_mode != M_RUN || rt) ? 0 : m_run_cnt + 1;
    m_adj_cnt   = (m_mode != M_ADJ || at) ? 0 : m_adj_cnt + 1;
    m_blink_cnt = bt ? 0 : m_blink_cnt + 1;
    m_scan_cnt  = st ? 0 : m_scan_cnt + 1;
    if (bt) m_blink = !m_blink;
    if (st) m_scan = (m_scan + 1) % 4;
    case (m_mode)
      M_RUN: begin
        if (a) m_mode = M_ADJ;
        else if (p) begin m_mode = M_PAUSED; m_flag = 1'b1; end
      end
      M_PAUSED: begin
        if (a) m_mode = M_ADJ;
        else if (p) begin m_mode = M_RUN; m_flag = 1'b0; end
      end
      default: begin
        if (p) m_flag = !m_flag;
        if (!a) m_mode = m_flag ? M_PAUSED : M_RUN;
      end
    endcase
    m_mask = (m_mode == M_ADJ && m_blink) ? (s ? 4'b0011 : 4'b1100) : 4'b0000;
  endtask

  task automatic check_all(input string tag);
    logic [15:0] got_t, exp_t;
    got_t = {min_ten, min_one, sec_ten, sec_one};
    exp_t = {4'(m_t / 600), 4'((m_t / 60) % 10), 4'((m_t % 60) / 10), 4'(m_t % 10)};
    checks++;
    assert (got_t === exp_t) else begin
      errors++; $error("FAIL %s time: got %h exp %h", tag, got_t, exp_t);
    end
    checks++;
    assert (paused === m_flag) else begin
      errors++; $error("FAIL %s paused: got %b exp %b", tag, paused, m_flag);
    end
    checks++;
    assert (scan_sel === 2'(m_scan)) else begin
      errors++; $error("FAIL %s scan_sel: got %0d exp %0d", tag, scan_sel, m_scan);
    end
    checks++;
    assert (blank_mask === m_mask) else begin
      errors++; $error("FAIL %s blank_mask: got %b exp %b", tag, blank_mask, m_mask);
    end
  endtask

  task automatic check_time(input string tag, input logic [15:0] exp_t);
    logic [15:0] got_t;
    got_t = {min_ten, min_one, sec_ten, sec_one};
    checks++;
    assert (got_t === exp_t) else begin
      errors++; $error("FAIL %s time: got %h exp %h", tag, got_t, exp_t);
    end
  endtask

  task automatic check_bit(input string tag, input logic got, input logic exp_b);
    checks++;
    assert (got === exp_b) else begin
      errors++; $error("FAIL %s: got %b exp %b", tag, got, exp_b);
    end
  endtask

  task automatic check_mask(input string tag, input logic [3:0] exp_m);
    checks++;
    assert (blank_mask === exp_m) else begin
      errors++; $error("FAIL %s blank_mask: got %b exp %b", tag, blank_mask, exp_m);
    end
  endtask

  // Apply inputs for one edge, advance model, sample 1 time unit after the edge
  task automatic step(input bit p, input bit c, input bit a, input bit s, input string tag);
    pause_pulse = p; clr_pulse = c; adj = a; sel = s;
    @(posedge clk);
    model_step(p, c, a, s);
    #1;
    pause_pulse = 1'b0; clr_pulse = 1'b0;
    check_all(tag);
  endtask

  initial begin
    bit a_lvl, s_lvl, p_r, c_r, saw_blank;

    // Reset state
    model_reset();
    #12;
    check_all("reset");
    check_time("reset_const", 16'h0000);
    rst_n = 1'b1;

    // Free run: 100 cycles -> 00:10
    repeat (100) step(0, 0, 0, 0, "run");
    check_time("run_100", 16'h0010);
    check_bit("run_paused", paused, 1'b0);

    // Adjust minutes to 59, then seconds to 59, exit and wrap to 00:00
    for (int i = 0; i < 400 && (m_t / 60) != 59; i++) step(0, 0, 1, 0, "adj_min");
    check_time("adj_min59", 16'h5910);
    for (int i = 0; i < 400 && (m_t % 60) != 59; i++) step(0, 0, 1, 1, "adj_sec");
    check_time("adj_sec59", 16'h5959);
    step(0, 0, 0, 1, "adj_exit");
    repeat (10) step(0, 0, 0, 0, "wrap");
    check_time("full_wrap", 16'h0000);

    // Pause at 00:03, hold for 60 cycles, resume for one second
    for (int i = 0; i < 100 && m_t != 3; i++) step(0, 0, 0, 0, "to3");
    step(1, 0, 0, 0, "pause");
    repeat (60) step(0, 0, 0, 0, "paused");
    check_time("pause_hold", 16'h0003);
    check_bit("pause_flag", paused, 1'b1);
    step(1, 0, 0, 0, "resume");
    repeat (10) step(0, 0, 0, 0, "resumed");
    check_time("resume_sec", 16'h0004);
    check_bit("resume_flag", paused, 1'b0);

    // Seconds field wraps 58 -> 59 -> 00 without touching minutes
    for (int i = 0; i < 400 && (m_t % 60) != 58; i++) step(0, 0, 1, 1, "to58");
    check_time("adj_58", 16'h0058);
    for (int i = 0; i < 20 && (m_t % 60) != 0; i++) step(0, 0, 1, 1, "sec_wrap");
    check_time("no_carry", 16'h0000);
    step(0, 0, 0, 1, "adj_exit2");

    // Clear coinciding with a run tick at 00:07
    for (int i = 0; i < 200 && !(m_t == 7 && m_run_cnt == RUN_DIV - 1); i++)
      step(0, 0, 0, 0, "to7");
    check_time("at7", 16'h0007);
    step(0, 1, 0, 0, "clr_tick");
    check_time("clr_wins", 16'h0000);
    repeat (9) step(0, 0, 0, 0, "after_clr");
    check_time("clr_full_sec_pre", 16'h0000);
    step(0, 0, 0, 0, "after_clr");
    check_time("clr_full_sec", 16'h0001);

    // Minutes blink in adjust, mask drops on exit
    saw_blank = 1'b0;
    repeat (16) begin
      step(0, 0, 1, 0, "blink");
      if (blank_mask == 4'b1100) saw_blank = 1'b1;
    end
    check_bit("blink_seen", saw_blank, 1'b1);
    step(0, 0, 0, 0, "blink_exit");
    check_mask("blink_exit_mask", 4'b0000);

    // Randomized mix of all inputs
    a_lvl = 1'b0; s_lvl = 1'b0;
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 39) == 0) a_lvl = !a_lvl;
      if ($urandom_range(0, 19) == 0) s_lvl = !s_lvl;
      p_r = ($urandom_range(0, 11) == 0);
      c_r = ($urandom_range(0, 59) == 0);
      step(p_r, c_r, a_lvl, s_lvl, "rand");
    end

    // Asynchronous reset mid-operation, then restart as from power-up
    adj = 1'b0; sel = 1'b0;
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all("async_rst");
    check_time("async_rst_const", 16'h0000);
    #10;
    rst_n = 1'b1;
    repeat (RUN_DIV - 1) step(0, 0, 0, 0, "post_rst");
    check_time("post_rst_pre", 16'h0000);
    step(0, 0, 0, 0, "post_rst");
    check_time("post_rst_tick", 16'h0001);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/stopwatch_ctrl.md
STOPWATCH_CTRL -- requirements
Module: stopwatch_ctrl

Interface
REQ-001 Parameter RUN_DIV, default 100_000_000, clk cycles per run tick (1 Hz).
REQ-002 Parameter ADJ_DIV, default 50_000_000, clk cycles per adjust tick (2 Hz).
REQ-003 Parameter BLINK_DIV, default 25_000_000, clk cycles per blink-phase toggle.
REQ-004 Parameter SCAN_DIV, default 200_000, clk cycles per digit-scan advance.
REQ-005 clk  in  1  sole clock; all state SHALL change on its rising edge only.
REQ-006 rst_n  in  1  asynchronous, active-low reset.
REQ-007 pause_pulse  in  1  debounced one-cycle pulse; toggles run/pause.
REQ-008 clr_pulse  in  1  debounced one-cycle pulse; clears time to 00:00.
REQ-009 adj  in  1  level; 1 = adjust mode.
REQ-010 sel  in  1  level; adjust field select, 0 = minutes, 1 = seconds.
REQ-011 sec_one, sec_ten, min_one, min_ten  out  4 each  BCD time digits, registered.
REQ-012 blank_mask  out  4  per-digit blank request, bit0 = sec_one ... bit3 = min_ten.
REQ-013 scan_sel  out  2  display digit index, 0 = sec_one ... 3 = min_ten.
REQ-014 paused  out  1  1 when the run/pause target is pause.

Function
REQ-015 Each divider SHALL count 0..DIV-1 and emit a one-cycle tick in the cycle its count equals DIV-1, then wrap to 0.
REQ-016 FSM states SHALL be RUN, PAUSED, ADJUST; reset state RUN.
REQ-017 RUN: each run tick SHALL increment time by one second, BCD, sec_one 9->0 carries into sec_ten, sec_ten 5->0 carries into min_one, min_one 9->0 carries into min_ten, 59:59 -> 00:00.
REQ-018 RUN: pause_pulse -> PAUSED; PAUSED: pause_pulse -> RUN; PAUSED SHALL ignore run ticks.
REQ-019 adj=1 in RUN or PAUSED SHALL enter ADJUST next cycle; adj wins over a simultaneous pause_pulse.
REQ-020 ADJUST: a return target flag (= paused output) SHALL be held; pause_pulse toggles it; adj=0 exits to PAUSED if flag=1, else RUN.
REQ-021 ADJUST: each adjust tick SHALL increment the selected two-digit field by 1 mod 60 with no carry into the other field; run ticks ignored.
REQ-022 Run divider SHALL be held at 0 while in ADJUST or PAUSED, and cleared on clr_pulse, so the first second after resume/clear is a full RUN_DIV cycles.
REQ-023 clr_pulse SHALL set all digits to 0 next cycle in any state, FSM state unchanged; clear wins over a simultaneous run or adjust tick.
REQ-024 Digit outputs SHALL reflect a tick/clear in the cycle after it (latency 1).
REQ-025 Blink phase SHALL toggle on each blink tick; in ADJUST with phase=1, blank_mask = 4'b1100 (sel=0) or 4'b0011 (sel=1); otherwise 4'b0000.
REQ-026 scan_sel SHALL increment mod 4 on each scan tick in every state.
REQ-027 Digits SHALL never leave range: sec_ten, min_ten 0..5; sec_one, min_one 0..9.

Reset
REQ-028 rst_n=0 SHALL immediately force digits 0, state RUN, paused 0, blink phase 0, blank_mask 0, scan_sel 0, all divider counts 0.
REQ-029 Reset deasserted mid-operation SHALL restart counting exactly as from power-up; first run tick RUN_DIV cycles after release.

Structure
REQ-030 Package stopwatch_pkg SHALL hold the state enum (RUN, PAUSED, ADJUST), default divider constants and digit-limit constants (9, 5).
REQ-031 One sub-module tick_divider (parameter DIV, inputs clk, rst_n, clear, hold; output tick) SHALL be instanced four times.
REQ-032 Digit increment logic SHALL be one shared mod-60 BCD incrementer function in the package.

Verification (RUN_DIV=10, ADJ_DIV=5, BLINK_DIV=4, SCAN_DIV=2)
REQ-033 Release reset, run 100 cycles -> time 00:10, scan_sel cycled 0..3 every 8 cycles, paused=0.
REQ-034 ADJUST sel=0 to 59 then sel=1 to 59, adj=0, 10 cycles -> 00:00 (full wrap).
REQ-035 pause_pulse at 00:03, wait 60 cycles -> still 00:03, paused=1; second pulse, 10 cycles -> 00:04.
REQ-036 ADJUST sel=1 from 00:58, two adjust ticks -> 00:00, minutes unchanged (no carry).
REQ-037 clr_pulse in same cycle as run tick at 00:07 -> 00:00 next cycle; next increment 10 cycles later.
REQ-038 ADJUST sel=0 -> blank_mask alternates 4'b1100/4'b0000 every 4 cycles; adj=0 -> 4'b0000 next cycle.
